// File: rtl/cw_target.sv
// CW pad-bus target: decodes an address window and turns each bus transaction
// into one request/acknowledge access on the local memory port.
module cw_target #(
  parameter logic [15:0] ADDR_BASE = 16'h8000,
  parameter logic [15:0] ADDR_MASK = 16'hF000,
  parameter int unsigned TIMEOUT   = 32
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [15:0] cw_io_i,
  output logic [15:0] cw_io_o,
  output logic        cw_io_oe,
  input  logic        cw_req,
  input  logic        cw_dir,
  output logic        cw_ack,
  output logic        cw_err,
  output logic        m_req,
  output logic        m_we,
  output logic [15:0] m_addr,
  output logic [15:0] m_wdata,
  input  logic [15:0] m_rdata,
  input  logic        m_ack
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WDATA,
    S_MEM,
    S_RESP,
    S_TURN
  } state_e;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic        we_q, we_d;
  logic        ok_q, ok_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata_q, rdata_d;

  function automatic logic addr_hit(input logic [15:0] a);
    return (a & ADDR_MASK) == (ADDR_BASE & ADDR_MASK);
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      ok_q    <= 1'b0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      ok_q    <= ok_d;
      cnt_q   <= cnt_d;
    end
  end

  // Datapath registers need no reset: every output using them is gated by state.
  always_ff @(posedge i_clk) begin
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    rdata_q <= rdata_d;
  end

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    ok_d    = ok_q;
    cnt_d   = 8'd0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (cw_req) begin
          addr_d = cw_io_i;
          we_d   = cw_dir;
          if (cw_dir) begin
            state_d = S_WDATA;
          end else if (addr_hit(cw_io_i)) begin
            state_d = S_MEM;
          end else begin
            ok_d    = 1'b0;
            state_d = S_RESP;
          end
        end
      end
      S_WDATA: begin
        wdata_d = cw_io_i;
        if (addr_hit(addr_q)) begin
          state_d = S_MEM;
        end else begin
          ok_d    = 1'b0;
          state_d = S_RESP;
        end
      end
      S_MEM: begin
        // An ack in the last allowed cycle still wins over the timeout.
        if (m_ack) begin
          if (!we_q) rdata_d = m_rdata;
          ok_d    = 1'b1;
          state_d = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          ok_d    = 1'b0;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_RESP:  state_d = S_TURN;
      S_TURN:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign m_req    = (state_q == S_MEM);
  assign m_we     = m_req & we_q;
  assign m_addr   = m_req ? addr_q : 16'h0000;
  assign m_wdata  = m_req ? wdata_q : 16'h0000;
  assign cw_ack   = (state_q == S_RESP) & ok_q;
  assign cw_err   = (state_q == S_RESP) & ~ok_q;
  assign cw_io_oe = cw_ack & ~we_q;
  assign cw_io_o  = cw_io_oe ? rdata_q : 16'h0000;

endmodule

// File: tb/tb_cw_target.sv
// Bench for cw_target: directed scenarios plus random transactions, each checked
// cycle by cycle against latencies derived from the bus rules.
module tb_cw_target;

  localparam int TO = 4;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic [15:0] cw_io_i;
  logic [15:0] cw_io_o;
  logic        cw_io_oe;
  logic        cw_req;
  logic        cw_dir;
  logic        cw_ack;
  logic        cw_err;
  logic        m_req;
  logic        m_we;
  logic [15:0] m_addr;
  logic [15:0] m_wdata;
  logic [15:0] m_rdata;
  logic        m_ack;

  int tests = 0;
  int fails = 0;

  cw_target #(
    .ADDR_BASE(16'h8000),
    .ADDR_MASK(16'hF000),
    .TIMEOUT  (TO)
  ) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .cw_io_i (cw_io_i),
    .cw_io_o (cw_io_o),
    .cw_io_oe(cw_io_oe),
    .cw_req  (cw_req),
    .cw_dir  (cw_dir),
    .cw_ack  (cw_ack),
    .cw_err  (cw_err),
    .m_req   (m_req),
    .m_we    (m_we),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_rdata (m_rdata),
    .m_ack   (m_ack)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic is_hit(input logic [15:0] a);
    return (a & 16'hF000) == 16'h8000;
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic e_mreq, input logic e_we,
                            input logic [15:0] e_addr, input logic [15:0] e_wd,
                            input logic chk_wd, input logic e_ack, input logic e_err,
                            input logic e_oe, input logic [15:0] e_io);
    chk({tag, ".m_req"}, {15'd0, m_req}, {15'd0, e_mreq});
    chk({tag, ".cw_ack"}, {15'd0, cw_ack}, {15'd0, e_ack});
    chk({tag, ".cw_err"}, {15'd0, cw_err}, {15'd0, e_err});
    chk({tag, ".cw_io_oe"}, {15'd0, cw_io_oe}, {15'd0, e_oe});
    chk({tag, ".cw_io_o"}, cw_io_o, e_io);
    if (e_mreq) begin
      chk({tag, ".m_we"}, {15'd0, m_we}, {15'd0, e_we});
      chk({tag, ".m_addr"}, m_addr, e_addr);
      if (chk_wd) chk({tag, ".m_wdata"}, m_wdata, e_wd);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_outs(tag, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    chk({tag, ".m_we"}, {15'd0, m_we}, 16'h0);
    chk({tag, ".m_addr"}, m_addr, 16'h0);
    chk({tag, ".m_wdata"}, m_wdata, 16'h0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge i_clk);
      check_outs("idle", 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
      cw_req  = 1'b0;
      cw_io_i = 16'($urandom);
      cw_dir  = 1'($urandom);
      m_ack   = 1'($urandom);
      m_rdata = 16'($urandom);
    end
  endtask

  // One full transaction from the IDLE cycle that samples the address through TURN.
  // Expected timing: optional data beat, then min(waits+1, TO) memory cycles on a hit,
  // then one response cycle and one turnaround cycle.
  task automatic txn(input string tag, input logic [15:0] addr, input logic dir,
                     input logic [15:0] wdata, input int waits, input logic [15:0] rdata,
                     input logic hold, input logic flaky);
    int   pre;
    int   mcyc;
    int   resp;
    logic ok;
    pre = dir ? 1 : 0;
    if (is_hit(addr)) begin
      ok   = (waits < TO);
      mcyc = ok ? waits + 1 : TO;
    end else begin
      ok   = 1'b0;
      mcyc = 0;
    end
    resp = 1 + pre + mcyc;
    @(negedge i_clk);
    check_outs({tag, ".t0"}, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    cw_req  = 1'b1;
    cw_io_i = addr;
    cw_dir  = dir;
    m_ack   = 1'($urandom);
    m_rdata = 16'($urandom);
    for (int k = 1; k <= resp + 1; k++) begin
      logic in_mem;
      logic e_ack;
      logic e_err;
      logic e_oe;
      in_mem = (k >= 1 + pre) && (k < 1 + pre + mcyc);
      e_ack  = (k == resp) && ok;
      e_err  = (k == resp) && !ok;
      e_oe   = e_ack && !dir;
      @(negedge i_clk);
      check_outs(tag, in_mem, dir, addr, wdata, dir, e_ack, e_err, e_oe, e_oe ? rdata : 16'h0);
      cw_io_i = (k == 1 && dir) ? wdata : 16'($urandom);
      cw_dir  = 1'($urandom);
      if (in_mem) begin
        m_ack   = (k - 1 - pre == waits);
        m_rdata = m_ack ? rdata : 16'($urandom);
      end else begin
        m_ack   = 1'($urandom);
        m_rdata = 16'($urandom);
      end
      if (k < resp) cw_req = flaky ? 1'($urandom) : 1'b1;
      else          cw_req = hold;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "bench time limit exceeded");
  end

  initial begin
    logic [15:0] a;
    i_rst   = 1'b1;
    cw_req  = 1'b0;
    cw_dir  = 1'b0;
    cw_io_i = 16'h0;
    m_ack   = 1'b0;
    m_rdata = 16'h0;
    repeat (2) @(negedge i_clk);
    check_reset_vals("reset");
    i_rst = 1'b0;
    idle(2);

    txn("rd_hit", 16'h8004, 1'b0, 16'h0, 0, 16'hBEEF, 1'b0, 1'b0);
    txn("wr_wait3", 16'h8010, 1'b1, 16'h1234, 3, 16'h0, 1'b0, 1'b0);
    txn("rd_miss", 16'h1000, 1'b0, 16'h0, 0, 16'h0, 1'b0, 1'b0);
    txn("wr_miss", 16'h0000, 1'b1, 16'hA5A5, 0, 16'h0, 1'b0, 1'b0);
    txn("rd_tmo", 16'h8020, 1'b0, 16'h0, 99, 16'h0, 1'b0, 1'b0);
    txn("rd_ack_last", 16'h8020, 1'b0, 16'h0, TO - 1, 16'h5A3C, 1'b0, 1'b0);
    txn("wr_tmo", 16'h8FFE, 1'b1, 16'h7777, 99, 16'h0, 1'b0, 1'b0);

    // Reset while a write is in its memory phase.
    @(negedge i_clk);
    cw_req  = 1'b1;
    cw_io_i = 16'h8010;
    cw_dir  = 1'b1;
    m_ack   = 1'b0;
    @(negedge i_clk);
    cw_io_i = 16'hC0DE;
    @(negedge i_clk);
    chk("rst_mem.m_req", {15'd0, m_req}, 16'h1);
    chk("rst_mem.m_wdata", m_wdata, 16'hC0DE);
    i_rst = 1'b1;
    @(negedge i_clk);
    check_reset_vals("rst_mem.after");
    i_rst  = 1'b0;
    cw_req = 1'b0;
    idle(3);
    txn("rd_after_rst", 16'h8000, 1'b0, 16'h0, 1, 16'h0F0F, 1'b0, 1'b0);

    // Stuck request: held through TURN, retriggers exactly once, then dropped.
    txn("b2b_a", 16'h8100, 1'b0, 16'h0, 0, 16'h1111, 1'b1, 1'b0);
    txn("b2b_b", 16'h8100, 1'b0, 16'h0, 0, 16'h2222, 1'b0, 1'b0);
    idle(3);

    for (int n = 0; n < 40; n++) begin
      a = (($urandom % 2) == 0) ? {4'h8, 12'($urandom)} : 16'($urandom);
      txn("rand", a, 1'($urandom), 16'($urandom), $urandom_range(0, TO + 1),
          16'($urandom), 1'($urandom), 1'($urandom));
    end
    idle(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
